// File: rtl/uart_rx_ctrl_if.sv
// Receive-side stream of uart_rx_ctrl: FIFO head, handshake, status pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_ctrl_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output data_out, data_valid, frame_err, overrun, busy,
        input  data_ready
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  data_out, data_valid, frame_err, overrun, busy,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver (8N1, optional parity via UART_RX_PARITY_EN) with mid-bit
// sampling and a small pointer-based receive FIFO.
//
// state  | meaning
// IDLE   | waiting for rx_s falling edge while rx_en=1
// START  | half-bit wait, confirm start bit still low
// DATA   | sample 8 data bits LSB first at mid-bit
// PARITY | sample parity bit at mid-bit (UART_RX_PARITY_EN only)
// STOP   | sample stop bit, push byte or flag error, back to IDLE
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx_en,
    input  logic           rx_in,
    uart_rx_ctrl_if.master rx_bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;

    localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] CNT_FULL = 16'(CLKS_PER_BIT - 1);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    logic        rx_m, rx_s;
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        cnt_done;
    logic        stop_done;
    logic        push_req, push_ok, pop;
    logic        frame_err_d, overrun_d;
    logic        full, empty;
    logic [AW:0] wptr, rptr;
    logic [7:0]  mem [FIFO_DEPTH];

`ifdef UART_RX_PARITY_EN
    logic        par_bit;
    logic        par_bad;
    logic        parity_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    assign cnt_done  = (cnt == 16'd0);
    assign stop_done = (state == S_STOP) && cnt_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_en && !rx_s) begin
                        state <= S_START;
                        cnt   <= CNT_HALF;
                    end
                end
                S_START: begin
                    if (cnt_done) begin
                        // line back high at mid start bit: a glitch, not a frame
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            cnt     <= CNT_FULL;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_done) begin
                        shift[bit_idx] <= rx_s;
                        cnt            <= CNT_FULL;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_done) begin
                        par_bit <= rx_s;
                        cnt     <= CNT_FULL;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_done) state <= S_IDLE;
                    else          cnt   <= cnt - 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && rx_bus.data_ready;

    always_comb begin
`ifdef UART_RX_PARITY_EN
        par_bad      = ((^shift) ^ par_bit) != PARITY_ODD;
        parity_err_d = stop_done && par_bad;
        push_req     = stop_done && rx_s && !par_bad;
`else
        push_req     = stop_done && rx_s;
`endif
        frame_err_d = stop_done && !rx_s;
        // a pop in the same cycle frees the slot the push needs
        push_ok     = push_req && (!full || pop);
        overrun_d   = push_req && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr             <= '0;
            rptr             <= '0;
            rx_bus.frame_err <= 1'b0;
            rx_bus.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_bus.parity_err <= 1'b0;
`endif
        end else begin
            if (push_ok) wptr <= wptr + PTR_ONE;
            if (pop)     rptr <= rptr + PTR_ONE;
            rx_bus.frame_err <= frame_err_d;
            rx_bus.overrun   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            rx_bus.parity_err <= parity_err_d;
`endif
        end
    end

    assign rx_bus.data_valid = !empty;
    assign rx_bus.data_out   = empty ? 8'h00 : mem[rptr[AW-1:0]];
    assign rx_bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl (CLKS_PER_BIT=16, FIFO_DEPTH=4, 8N1):
// stimulus queues expected bytes/error events, a monitor pops and compares.
module tb_uart_rx_ctrl;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_en;
    logic rx_in;

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_en  (rx_en),
        .rx_in  (rx_in),
        .rx_bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_bytes[$];
    logic [1:0] exp_evt[$];   // {overrun, frame_err}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // starts on a falling clock edge; drives start, 8 data bits LSB first, stop
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"},   32'(bus.data_out),   32'h00);
        check({tag, "_data_valid"}, 32'(bus.data_valid), 32'h0);
        check({tag, "_frame_err"},  32'(bus.frame_err),  32'h0);
        check({tag, "_overrun"},    32'(bus.overrun),    32'h0);
        check({tag, "_busy"},       32'(bus.busy),       32'h0);
    endtask

    // monitor: samples 2 time units after each falling edge
    initial begin
        logic [1:0] ev;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus.data_valid && bus.data_ready) begin
                    if (exp_bytes.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %0h, expected none (t=%0t)", bus.data_out, $time);
                    end else begin
                        check("rx_byte", 32'(bus.data_out), 32'(exp_bytes.pop_front()));
                    end
                end
                ev = {bus.overrun, bus.frame_err};
                if (ev != 2'b00) begin
                    if (exp_evt.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_event: got %0b, expected none (t=%0t)", ev, $time);
                    end else begin
                        check("error_event", 32'(ev), 32'(exp_evt.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rx_en = 1'b1;
        rx_in = 1'b1;
        bus.data_ready = 1'b0;
        @(negedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single frame
        bus.data_ready = 1'b1;
        exp_bytes.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        #2;
        check("single_empty_after", 32'(bus.data_valid), 32'h0);

        // glitch: 4 low cycles, START entered then abandoned
        @(negedge clk);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        check("glitch_busy_in_start", 32'(bus.busy), 32'h1);
        repeat (12) @(negedge clk);
        #2;
        check("glitch_back_idle", 32'(bus.busy), 32'h0);
        check("glitch_no_push", 32'(bus.data_valid), 32'h0);

        // framing error
        @(negedge clk);
        exp_evt.push_back(2'b01);
        send_frame(8'h3C, 1'b0);
        repeat (30) @(negedge clk);
        #2;
        check("ferr_fifo_empty", 32'(bus.data_valid), 32'h0);

        // overrun: five frames into a 4-deep FIFO with no consumer
        @(negedge clk);
        bus.data_ready = 1'b0;
        for (int i = 1; i <= 4; i++) exp_bytes.push_back(8'(i));
        exp_evt.push_back(2'b10);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (20) @(negedge clk);
        #2;
        check("ovr_valid_held", 32'(bus.data_valid), 32'h1);
        check("ovr_head", 32'(bus.data_out), 32'h01);
        @(negedge clk);
        bus.data_ready = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        check("ovr_drained", 32'(bus.data_valid), 32'h0);

        // full FIFO, pop coincides with the push of the fifth byte
        @(negedge clk);
        bus.data_ready = 1'b0;
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h44);
        exp_bytes.push_back(8'h55);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        fork
            send_frame(8'h55, 1'b1);
            begin
                // stop-bit sample edge falls 155 rising edges after the start edge
                repeat (154) @(negedge clk);
                bus.data_ready = 1'b1;
                @(negedge clk);
                bus.data_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        #2;
        check("pop_push_head", 32'(bus.data_out), 32'h22);
        @(negedge clk);
        bus.data_ready = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        check("pop_push_drained", 32'(bus.data_valid), 32'h0);

        // rx_en dropped mid-frame does not abort it
        @(negedge clk);
        exp_bytes.push_back(8'h77);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (40) @(negedge clk);
                rx_en = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        #2;
        check("rxen_frame_done", 32'(bus.data_valid), 32'h0);

        // rx_en low blocks a new frame entirely
        @(negedge clk);
        send_frame(8'h0F, 1'b1);
        repeat (20) @(negedge clk);
        #2;
        check("rxen_blocked_busy", 32'(bus.busy), 32'h0);
        check("rxen_blocked_empty", 32'(bus.data_valid), 32'h0);
        @(negedge clk);
        rx_en = 1'b1;
        repeat (4) @(negedge clk);

        // reset mid-frame after bit 3 of 0xFF
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (80) @(negedge clk);
                rst_n = 1'b0;
                #2;
                check_reset_outputs("midrst");
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        #2;
        check("midrst_no_push", 32'(bus.data_valid), 32'h0);
        check("midrst_idle", 32'(bus.busy), 32'h0);
        @(negedge clk);
        exp_bytes.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);

        #2;
        check("bytes_outstanding", 32'(exp_bytes.size()), 32'h0);
        check("events_outstanding", 32'(exp_evt.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per bit period (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive-buffer entries; power of two, range 2..16.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_en  input  1  receive enable; gates only the start of a new frame.
REQ-006 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data_out  output  8  byte at the FIFO head.
REQ-008 SHALL have port data_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port data_ready  input  1  consumer accepts data_out when data_valid=1.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL pass rx_in through a 2-flop synchronizer; all sampling SHALL use the synchronized value, rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, plus PARITY when the macro is defined.
REQ-015 In IDLE with rx_en=1 and rx_s=0, SHALL enter START and load the bit counter with CLKS_PER_BIT/2-1 (integer division).
REQ-016 On counter expiry in START: if rx_s=1, SHALL treat it as a glitch and return to IDLE with no error; else SHALL enter DATA, load CLKS_PER_BIT-1, and clear the bit index.
REQ-017 In DATA, SHALL sample rx_s at each counter expiry into shift bit [index], LSB first, and reload CLKS_PER_BIT-1; after index 7 SHALL go to STOP (or PARITY).
REQ-018 In STOP at expiry: if rx_s=1, SHALL push the byte into the FIFO; else SHALL pulse frame_err and discard the byte; then SHALL go to IDLE in the same cycle.
REQ-019 Sampling instants SHALL fall at bit mid-points: data bit n is sampled (CLKS_PER_BIT/2)+(n+1)*CLKS_PER_BIT cycles, ±1, after the rx_s falling edge.
REQ-020 Deasserting rx_en mid-frame SHALL NOT abort the frame; only the next IDLE->START transition is blocked.
REQ-021 The FIFO SHALL use read/write pointers with one extra wrap bit: full when the pointers differ only in the MSB, empty when they are equal.
REQ-022 A pop SHALL occur when data_valid&&data_ready; data_out SHALL show the new head on the next cycle.
REQ-023 A push into a full FIFO SHALL pulse overrun and drop the new byte, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-024 A push into an empty FIFO SHALL assert data_valid on the following cycle (one-cycle latency).
REQ-025 frame_err and overrun SHALL NOT assert in the same cycle; a frame_err byte is never pushed.

Reset
REQ-026 On rst_n=0, SHALL immediately set FSM=IDLE, counter=0, index=0, FIFO pointers=0, synchronizer flops=1.
REQ-027 During reset, SHALL drive data_out=8'h00, data_valid=0, frame_err=0, overrun=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte; after release, the FSM SHALL require a new falling edge on rx_s.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined, SHALL add parameter PARITY_ODD (default 0 = even), output parity_err (1-bit pulse), and state PARITY between DATA and STOP, sampled at mid-bit.
REQ-030 With UART_RX_PARITY_EN defined and a parity mismatch, SHALL pulse parity_err at the STOP expiry and discard the byte; a simultaneous stop-bit error SHALL pulse both parity_err and frame_err.
REQ-031 Without UART_RX_PARITY_EN, SHALL have no parity_err port and no PARITY state; the frame is 8N1.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-032 SHALL verify single frame: send 0xA5 as 8N1 with data_ready=1 -> data_valid pulses once with data_out=0xA5 and no errors.
REQ-033 SHALL verify glitch rejection: drive rx_in low for 4 cycles in IDLE -> FSM returns to IDLE, no push, no error.
REQ-034 SHALL verify framing error: send 0x3C with stop bit 0 -> frame_err pulses for exactly 1 cycle and the FIFO stays empty.
REQ-035 SHALL verify overrun: send 5 frames (0x01..0x05) with data_ready=0 -> 4 bytes are buffered, overrun pulses on the 5th, then data drains as 0x01..0x04.
REQ-036 SHALL verify full with simultaneous pop: FIFO full, data_ready=1 in the push cycle -> no overrun, and the order is preserved.
REQ-037 SHALL verify mid-frame reset: rst_n pulsed low after bit 3 of 0xFF -> no push, outputs at reset values, and the next frame 0x5A is received correctly.
